sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_pkg.sv | 20 ++
 rtl/sdram_arbiter_picker.sv | 33 +++
 rtl/sdram_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter and the SDRAM controller.
// Holds the bus widths, the controller command encoding and the arbiter state encoding.
package sdram_pkg;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 16;

  // Command to the controller; encoding 3 is reserved and never driven.
  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2
  } cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_picker.sv
// round_robin_picker: combinational round-robin selector.
// Ports:
//   request      - per-port request vector
//   last_granted - index of the most recent grant; the search starts one past it
//   valid        - some request bit is set
//   index        - first requesting port at or after last_granted+1 (wrapping)
module round_robin_picker #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [IW-1:0]        last_granted,
  output logic                 valid,
  output logic [IW-1:0]        index
);

  int unsigned pos;

  // Walk offsets 1..NUM_PORTS so last_granted itself is checked last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    pos   = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      pos = (32'(last_granted) + i) % NUM_PORTS;
      if (!valid && request[IW'(pos)]) begin
        valid = 1'b1;
        index = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter giving NUM_PORTS requesters access to one SDRAM controller.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   req/req_write/req_address/req_data - per-port request, op (1=write), address, write data
//   ack, error                 - per-port one-cycle completion / timeout pulses
//   read_data                  - data of the last completed read, valid with its ack
//   command, data_address, data_write - request to the controller (0 none, 1 write, 2 read)
//   data_read, data_read_valid, data_write_done - controller responses
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS-1:0]              req_write,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_address,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  req_data,
  output logic [NUM_PORTS-1:0]              ack,
  output logic [DATA_W-1:0]                 read_data,
  output logic [NUM_PORTS-1:0]              error,
  output logic [1:0]                        command,
  output logic [ADDR_W-1:0]                 data_address,
  output logic [DATA_W-1:0]                 data_write,
  input  logic [DATA_W-1:0]                 data_read,
  input  logic                              data_read_valid,
  input  logic                              data_write_done
);

  localparam int unsigned IW = $clog2(NUM_PORTS);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  arb_state_e  state;
  logic [IW-1:0] last_granted;
  logic [IW-1:0] owner;
  logic          hold_write;
  logic [TW-1:0] timer;

  logic          pick_valid;
  logic [IW-1:0] pick_index;
  logic          done_c;

  round_robin_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IW        (IW)
  ) u_picker (
    .request      (req),
    .last_granted (last_granted),
    .valid        (pick_valid),
    .index        (pick_index)
  );

  // Only the completion pulse matching the latched op counts.
  assign done_c = hold_write ? data_write_done : data_read_valid;

  // Arbiter FSM. data_address/data_write double as the holding registers.
  // No grant while ack/error is high: the finishing owner still shows req in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      command      <= CMD_NONE;
      ack          <= '0;
      error        <= '0;
      read_data    <= '0;
      data_address <= '0;
      data_write   <= '0;
      timer        <= '0;
      last_granted <= IW'(NUM_PORTS - 1);
      owner        <= '0;
      hold_write   <= 1'b0;
    end else begin
      ack   <= '0;
      error <= '0;
      case (state)
        ST_IDLE: begin
          command <= CMD_NONE;
          if (pick_valid && ack == '0 && error == '0) begin
            state        <= ST_BUSY;
            owner        <= pick_index;
            last_granted <= pick_index;
            hold_write   <= req_write[pick_index];
            command      <= req_write[pick_index] ? CMD_WRITE : CMD_READ;
            data_address <= req_address[pick_index];
            data_write   <= req_data[pick_index];
            timer        <= '0;
          end
        end
        ST_BUSY: begin
          // Completion takes precedence over a coincident timeout.
          if (done_c) begin
            ack[owner] <= 1'b1;
            command    <= CMD_NONE;
            state      <= ST_IDLE;
            if (!hold_write) begin
              read_data <= data_read;
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            error[owner] <= 1'b1;
            command      <= CMD_NONE;
            state        <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          command <= CMD_NONE;
        end
      endcase
    end
  end

endmodule
